// File: rtl/ppfifo_writer_pkg.sv
// rtl/ppfifo_writer_pkg.sv - shared FSM encoding and count width for the ping-pong FIFO writer
package ppfifo_writer_pkg;

  localparam int COUNT_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } writer_state_t;

endpackage

// File: rtl/ppfifo_writer.sv
// rtl/ppfifo_writer.sv - drains a valid/ready stream into the write side of a ping-pong FIFO
import ppfifo_writer_pkg::*;

module ppfifo_writer #(
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 64,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  input  logic [1:0]             write_ready,
  output logic [1:0]             write_activate,
  input  logic [COUNT_WIDTH-1:0] write_fifo_size,
  output logic                   write_strobe,
  output logic [DATA_WIDTH-1:0]  write_data,
  output logic                   block_done,
  output logic [COUNT_WIDTH-1:0] block_count
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_VAL = TIMEOUT_WIDTH'(TIMEOUT);

  writer_state_t              state;
  logic                       last_sel;
  logic [1:0]                 ready_q;
  logic [COUNT_WIDTH-1:0]     count;
  logic [COUNT_WIDTH-1:0]     count_next;
  logic [TIMEOUT_WIDTH-1:0]   idle_cnt;
  logic [TIMEOUT_WIDTH-1:0]   idle_next;
  logic                       beat;
  logic                       timeout_hit;
  logic                       release_now;
  logic                       pick;
  logic                       pick_ok;

  assign in_ready     = (state == ST_ACTIVE) && (count < write_fifo_size);
  assign beat         = in_valid && in_ready;
  assign write_strobe = beat;
  assign write_data   = beat ? in_data : '0;
  assign count_next   = count + COUNT_WIDTH'(beat);

  // Idle counter saturates so a long wait on an empty buffer never wraps into a false timeout.
  assign idle_next   = beat ? '0 :
                       (idle_cnt == '1) ? idle_cnt : idle_cnt + TIMEOUT_WIDTH'(1);
  assign timeout_hit = (TIMEOUT != 0) && (count != '0) && (idle_next == TIMEOUT_VAL);

  // A full buffer is seen on the registered count, so in_ready drops one cycle before release.
  assign release_now = (count == write_fifo_size) || (beat && in_last) || timeout_hit;

  assign pick    = ready_q[~last_sel] ? ~last_sel : last_sel;
  assign pick_ok = ready_q[pick];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      last_sel       <= 1'b1;
      ready_q        <= 2'b00;
      count          <= '0;
      idle_cnt       <= '0;
      write_activate <= 2'b00;
      block_done     <= 1'b0;
      block_count    <= '0;
    end else begin
      ready_q    <= write_ready;
      block_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_ok) begin
            state          <= ST_ACTIVE;
            write_activate <= pick ? 2'b10 : 2'b01;
            last_sel       <= pick;
            count          <= '0;
            idle_cnt       <= '0;
          end
        end
        ST_ACTIVE: begin
          count    <= count_next;
          idle_cnt <= idle_next;
          if (release_now) begin
            state          <= ST_RELEASE;
            write_activate <= 2'b00;
            block_done     <= 1'b1;
            block_count    <= count_next;
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
